// File: rtl/fc_pkg.sv
// fc_pkg: definitions shared by fc_layer_driver, fc_vec_serializer and the
// fc_layer1_flattened instances on the far side of the start/done interface.
//   FC_IN_SIZE  : elements per flattened input vector
//   FC_OUT_SIZE : elements per flattened output vector
//   FC_W        : element width in bits (signed, two's complement)
//   FC_TIMEOUT  : maximum WAIT cycles before a run is abandoned
//   fc_state_e  : sequencer states LOAD/START/WAIT/EMIT
package fc_pkg;

  localparam int FC_IN_SIZE  = 16;
  localparam int FC_OUT_SIZE = 8;
  localparam int FC_W        = 8;
  localparam int FC_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fc_vec_serializer.sv
// fc_vec_serializer: captures a flattened FC output vector and streams it out
// one element per valid/ready handshake, lowest index first.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : capture vec and start emitting from element 0
//   vec         : flattened vector, element k at [k*W +: W]
//   m_valid/m_ready/m_data/m_index/m_last : output element stream
//   emit_done   : handshake of the final element happened this cycle
module fc_vec_serializer
  import fc_pkg::*;
#(
  parameter int OUT_SIZE = FC_OUT_SIZE,
  parameter int W        = FC_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [W*OUT_SIZE-1:0]         vec,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [W-1:0]                  m_data,
  output logic [$clog2(OUT_SIZE)-1:0]   m_index,
  output logic                          m_last,
  output logic                          emit_done
);

  localparam int KW = $clog2(OUT_SIZE);
  localparam logic [KW-1:0] K_LAST = KW'(OUT_SIZE - 1);

  logic [W*OUT_SIZE-1:0] cap_q;
  logic [KW-1:0]         k_q;
  logic                  active_q;
  logic                  hs;

  assign hs = active_q & m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q    <= '0;
      k_q      <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cap_q    <= vec;
      k_q      <= '0;
      active_q <= 1'b1;
    end else if (hs) begin
      // k only advances on a handshake, so data/index/last hold during stalls
      if (k_q == K_LAST) begin
        k_q      <= '0;
        active_q <= 1'b0;
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign m_valid   = active_q;
  assign m_data    = cap_q[k_q*W +: W];
  assign m_index   = k_q;
  assign m_last    = active_q && (k_q == K_LAST);
  assign emit_done = hs && (k_q == K_LAST);

endmodule

// File: rtl/fc_layer_driver.sv
// fc_layer_driver: sequencer in front of fc_layer1_flattened. Gathers IN_SIZE
// elements from a stream into a flat vector, pulses fc_start, waits for
// fc_done (bounded by TIMEOUT), then streams the OUT_SIZE results out.
//   clk, reset          : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data               : input element stream
//   fc_start, fc_in_vector_flat          : start pulse and frozen input vector
//   fc_done, fc_out_vector_flat          : FC result strobe and vector
//   m_valid/m_ready/m_data/m_index/m_last: output element stream
//   busy         : high in START, WAIT, EMIT
//   timeout_err  : sticky, set when a run times out; cleared only by reset
//   dbg_state    : current sequencer state (fc_state_e encoding)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holds valid and its payload stable until that edge;
// ready may change freely and never depends on valid.
module fc_layer_driver
  import fc_pkg::*;
#(
  parameter int IN_SIZE  = FC_IN_SIZE,
  parameter int OUT_SIZE = FC_OUT_SIZE,
  parameter int W        = FC_W,
  parameter int TIMEOUT  = FC_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [W-1:0]                s_data,
  output logic                        fc_start,
  output logic [W*IN_SIZE-1:0]        fc_in_vector_flat,
  input  logic                        fc_done,
  input  logic [W*OUT_SIZE-1:0]       fc_out_vector_flat,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [W-1:0]                m_data,
  output logic [$clog2(OUT_SIZE)-1:0] m_index,
  output logic                        m_last,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [1:0]                  dbg_state
);

  localparam int IW = $clog2(IN_SIZE);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IN_LAST = IW'(IN_SIZE - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  fc_state_e             state_q, state_d;
  logic [IW-1:0]         in_cnt_q;
  logic [TW-1:0]         wait_cnt_q;
  logic                  timeout_err_q;
  logic [W*IN_SIZE-1:0]  in_vec_q;
  logic                  accept, capture, timed_out, emit_done;

  always_comb begin
    state_d   = state_q;
    accept    = (state_q == LOAD) && s_valid;
    // fc_done only counts in WAIT, so a level held over from START is ignored
    capture   = (state_q == WAIT) && fc_done;
    // done on the final allowed cycle still wins over the timeout
    timed_out = (state_q == WAIT) && !fc_done && (wait_cnt_q == TO_LAST);
    case (state_q)
      LOAD:    if (accept && (in_cnt_q == IN_LAST)) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (capture) state_d = EMIT;
               else if (timed_out) state_d = LOAD;
      EMIT:    if (emit_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD;
      in_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      in_vec_q      <= '0;
    end else begin
      state_q <= state_d;
      // slots are only written in LOAD, which freezes the vector for the run;
      // old slot values survive until overwritten by the next run
      if (accept) begin
        in_vec_q[in_cnt_q*W +: W] <= s_data;
        in_cnt_q <= (in_cnt_q == IN_LAST) ? '0 : in_cnt_q + 1'b1;
      end
      if ((state_q == WAIT) && !capture && !timed_out)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      else
        wait_cnt_q <= '0;
      if (timed_out)
        timeout_err_q <= 1'b1;
    end
  end

  fc_vec_serializer #(
    .OUT_SIZE (OUT_SIZE),
    .W        (W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .vec       (fc_out_vector_flat),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .emit_done (emit_done)
  );

  assign s_ready           = (state_q == LOAD);
  assign fc_start          = (state_q == START);
  assign busy              = (state_q != LOAD);
  assign fc_in_vector_flat = in_vec_q;
  assign timeout_err       = timeout_err_q;
  assign dbg_state         = state_q;

endmodule

// File: doc/fc_layer_driver.md
Name: fc_layer_driver

Overview:
Initiator/sequencer for fc_layer1_flattened; the block on the other end of its start/done, flattened-vector interface.
- Input side: collects IN_SIZE signed elements from a valid/ready stream into a flattened input vector.
- FC handshake: pulses start, waits for done, captures the flattened output vector.
- Output side: streams the OUT_SIZE results out one element per handshake.
- Sits between the feature stream and the FC layer, so upstream logic never builds or reads wide flat buses.

Parameters:
IN_SIZE, 16, elements per input vector
OUT_SIZE, 8, elements per output vector
W, 8, element width in bits (signed, two's complement)
TIMEOUT, 1024, max WAIT cycles before abort (must be ≥2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
s_valid  in  1  input element valid
s_ready  out  1  driver can accept an element
s_data  in  W  signed input element
fc_start  out  1  one-cycle start pulse to FC layer
fc_in_vector_flat  out  W*IN_SIZE  element i at [i*W +: W]
fc_done  in  1  FC result valid
fc_out_vector_flat  in  W*OUT_SIZE  element k at [k*W +: W]
m_valid  out  1  output element valid
m_ready  in  1  downstream accepts element
m_data  out  W  signed output element
m_index  out  $clog2(OUT_SIZE)  index k of m_data
m_last  out  1  high with element OUT_SIZE-1
busy  out  1  high in START, WAIT, EMIT
timeout_err  out  1  sticky: an FC run timed out

Behaviour:
- Reset (async, reset=0):
  - State LOAD; all counters 0; in/out capture registers 0.
  - fc_start=0, m_valid=0, m_last=0, m_data=0, m_index=0, busy=0, timeout_err=0, s_ready=1.
  - Reset mid-run aborts immediately. No partial output is emitted afterwards.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready: element goes to slot in_cnt; in_cnt increments.
  - On acceptance of slot IN_SIZE-1: go to START next cycle, s_ready drops.
  - Slot values from a previous run persist until overwritten.
- START:
  - fc_start=1 for exactly one cycle, then WAIT.
  - fc_in_vector_flat is frozen from START until re-entry to LOAD.
- WAIT:
  - fc_done is sampled only in WAIT, from the cycle after fc_start onward; fc_done high during START is ignored.
  - First WAIT cycle with fc_done=1: capture fc_out_vector_flat, clear wait counter, go to EMIT. Latency is done cycle + 1 → m_valid=1.
  - Wait counter reaching TIMEOUT-1 with fc_done=0: set timeout_err, discard the run, return to LOAD with in_cnt=0.
  - If fc_done and the timeout coincide, fc_done wins.
- EMIT:
  - m_valid=1; m_data = captured[k*W +: W]; m_index=k; m_last=(k==OUT_SIZE-1).
  - m_data, m_index and m_last stay stable while m_valid & !m_ready.
  - On handshake, k increments. Handshake with m_last → LOAD next cycle, k=0, m_valid=0.
  - Back-to-back m_ready gives one element per cycle.
- Timing and widths:
  - Minimum run is IN_SIZE + 1 + (FC latency) + OUT_SIZE cycles.
  - No overlap: s_ready=0 throughout START, WAIT and EMIT.
  - No arithmetic on data; elements pass bit-exact with sign preserved.
  - Counters are $clog2 of their range (+1 where needed) and never wrap past limits.
- timeout_err: cleared only by reset. Subsequent runs still operate normally.

Decomposition:
- Shared package fc_pkg:
  - state enum LOAD/START/WAIT/EMIT
  - FC_IN_SIZE=16, FC_OUT_SIZE=8, FC_W=8, FC_TIMEOUT=1024, shared with fc_layer1_flattened instances
- One sub-module, fc_vec_serializer: capture register, k counter, m_* handshake.
  - Controlled by load/start-emit strobes; returns emit_done.

Test Plan:
- Nominal run with a real fc_layer1_flattened (weights repeat 1,1,-1,0 per row; bias_i = -36+4i), stream inputs 1..16 with s_valid held high.
  - Expect one fc_start pulse, then m_data = -12,-8,-4,0,4,8,12,16.
  - m_index 0..7; m_last only on 16; then s_ready=1.
- Backpressure: repeat the run with m_ready toggling 1,0,0,1…
  - Each element is held stable across stalls.
  - Exactly 8 handshakes occur; output sequence is unchanged.
- Gapped input: s_valid random at 50% duty; s_data = -128,127,-1,0,… alternating.
  - fc_in_vector_flat slot i matches bit-exact, including sign.
  - fc_start occurs only after the 16th handshake.
- Timeout: stub responder never raises fc_done.
  - timeout_err=1 exactly 1024 WAIT cycles after fc_start; m_valid never asserts; s_ready=1 next cycle.
  - A following good run produces correct outputs with timeout_err still 1.
- Edges: stub holds fc_done=1 during START.
  - The START-cycle value is ignored; capture happens on the first WAIT cycle.
  - The stub's vector 0x01..0x08 is emitted as 1..8.
- Reset mid-EMIT: after 3 elements, pulse reset low for 1 cycle.
  - All outputs reach reset values asynchronously; m_valid=0 and stays 0 afterwards.
  - Next full run emits from index 0.
